// File: rtl/tt_pad_pkg.sv
// tt_pad_pkg -- shared definitions for the pad snapshot observer.
//
// Holds the frame FSM state encoding, the bit position of every field inside
// a per-pad snapshot byte, the CRC-8 polynomial, the default header bytes and
// the frame lengths for both build flavours.
//
// Build option: PAD_SNAPSHOT_CRC_EN adds the CRC state to the FSM encoding.
package tt_pad_pkg;

  // Per-pad byte layout, MSB to LSB: {PU,PD,CS,SL,IE,OE,A,Y_sync}
  localparam int unsigned BIT_Y  = 0;
  localparam int unsigned BIT_A  = 1;
  localparam int unsigned BIT_OE = 2;
  localparam int unsigned BIT_IE = 3;
  localparam int unsigned BIT_SL = 4;
  localparam int unsigned BIT_CS = 5;
  localparam int unsigned BIT_PD = 6;
  localparam int unsigned BIT_PU = 7;

  localparam int unsigned NUM_PADS = 16;

  localparam logic [7:0] CRC8_POLY          = 8'h07;
  localparam logic [7:0] HEADER_DEFAULT     = 8'hA5;
  localparam logic [7:0] HEADER_CRC_DEFAULT = 8'hA6;

  // header + 16 pad bytes + status (+ crc)
  localparam int unsigned FRAME_LEN_NO_CRC = 18;
  localparam int unsigned FRAME_LEN_CRC    = 19;

`ifdef PAD_SNAPSHOT_CRC_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAD,
    ST_STAT,
    ST_CRC
  } pad_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAD,
    ST_STAT
  } pad_state_e;
`endif

endpackage

// File: rtl/tt_pad_snapshot_crc8.sv
// tt_pad_snapshot_crc8 -- running CRC-8 over the bytes of one frame.
//
// Polynomial CRC8_POLY (0x07), init 0x00, MSB first, no reflection and no
// final XOR. Whole-byte combinational update feeding an accumulator.
//
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset (accumulator -> 0)
//   clr      synchronous clear, start of a new frame
//   upd      fold data_in into the accumulator on this edge
//   data_in  byte being transferred
//   crc      current accumulator value
module tt_pad_snapshot_crc8
  import tt_pad_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       upd,
  input  logic [7:0] data_in,
  output logic [7:0] crc
);

  logic [7:0] crc_reg;
  logic [7:0] crc_next;

  always_comb begin
    crc_next = crc_reg ^ data_in;
    for (int i = 0; i < 8; i++) begin
      crc_next = crc_next[7] ? ({crc_next[6:0], 1'b0} ^ CRC8_POLY)
                             : {crc_next[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg <= '0;
    end else if (clr) begin
      crc_reg <= '0;
    end else if (upd) begin
      crc_reg <= crc_next;
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/tt_pad_snapshot.sv
// tt_pad_snapshot -- captures the state of all 16 bidirectional pads on
// request and streams it out as a byte-wide valid/ready frame:
//   header, pad 15 .. pad 0, status {conflict_any, overrun, 0, count[4:0]}
//   (+ CRC-8 byte when PAD_SNAPSHOT_CRC_EN is defined).
//
// Build option: PAD_SNAPSHOT_CRC_EN -- append CRC-8, header becomes HEADER_CRC.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   tt_bi_Y                    pad inputs, asynchronous (synchronised here)
//   tt_bi_A/OE/IE/SL/CS/PD/PU  pad controls, synchronous to clk
//   snap_start                 capture request (honoured only when idle)
//   out_data/out_valid/out_ready  byte stream
//   busy                       frame in progress
//   done                       one-cycle pulse after the last byte transfers
module tt_pad_snapshot
  import tt_pad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  HEADER      = HEADER_DEFAULT,
  parameter logic [7:0]  HEADER_CRC  = HEADER_CRC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] tt_bi_Y,
  input  logic [15:0] tt_bi_A,
  input  logic [15:0] tt_bi_OE,
  input  logic [15:0] tt_bi_IE,
  input  logic [15:0] tt_bi_SL,
  input  logic [15:0] tt_bi_CS,
  input  logic [15:0] tt_bi_PD,
  input  logic [15:0] tt_bi_PU,
  input  logic        snap_start,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

`ifdef PAD_SNAPSHOT_CRC_EN
  localparam bit         CRC_EN   = 1'b1;
`else
  localparam bit         CRC_EN   = 1'b0;
`endif
  localparam logic [7:0] HDR_BYTE = CRC_EN ? HEADER_CRC : HEADER;

  genvar gi;

  // Y synchroniser
  logic [SYNC_STAGES-1:0][15:0] y_sync_reg;

  for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_sync_reg[gi] <= '0;
        else        y_sync_reg[gi] <= tt_bi_Y;
      end
    end else begin : g_rest
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_sync_reg[gi] <= '0;
        else        y_sync_reg[gi] <= y_sync_reg[gi-1];
      end
    end
  end

  // Snapshot assembly: pad p occupies bits [8p+7:8p]
  logic [8*NUM_PADS-1:0] snap_next;

  for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
    assign snap_next[8*gi + BIT_Y ] = y_sync_reg[SYNC_STAGES-1][gi];
    assign snap_next[8*gi + BIT_A ] = tt_bi_A[gi];
    assign snap_next[8*gi + BIT_OE] = tt_bi_OE[gi];
    assign snap_next[8*gi + BIT_IE] = tt_bi_IE[gi];
    assign snap_next[8*gi + BIT_SL] = tt_bi_SL[gi];
    assign snap_next[8*gi + BIT_CS] = tt_bi_CS[gi];
    assign snap_next[8*gi + BIT_PD] = tt_bi_PD[gi];
    assign snap_next[8*gi + BIT_PU] = tt_bi_PU[gi];
  end

  logic [4:0] count_next;
  always_comb begin
    count_next = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      count_next = count_next + 5'(tt_bi_PU[i] & tt_bi_PD[i]);
    end
  end

  pad_state_e            state_reg, state_next;
  logic [8*NUM_PADS-1:0] snapshot_reg;
  logic [4:0]            count_reg;
  logic [3:0]            idx_reg;
  logic                  overrun_reg;   // requests dropped during this frame
  logic                  rpt_ovr_reg;   // value this frame reports in STAT
  logic                  done_reg;

  logic xfer;
  logic capture;
  assign xfer    = out_valid && out_ready;
  assign capture = (state_reg == ST_IDLE) && snap_start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (snap_start) state_next = ST_HDR;
      ST_HDR:  if (xfer) state_next = ST_PAD;
      ST_PAD:  if (xfer && idx_reg == 4'd0) state_next = ST_STAT;
`ifdef PAD_SNAPSHOT_CRC_EN
      ST_STAT: if (xfer) state_next = ST_CRC;
      ST_CRC:  if (xfer) state_next = ST_IDLE;
`else
      ST_STAT: if (xfer) state_next = ST_IDLE;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef PAD_SNAPSHOT_CRC_EN
  logic [7:0] crc_value;
  tt_pad_snapshot_crc8 u_crc8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (capture),
    .upd     (xfer && state_reg != ST_CRC),
    .data_in (out_data),
    .crc     (crc_value)
  );
`endif

  // Output logic; out_data only depends on registered state, so it holds
  // steady across any number of stalled cycles.
  always_comb begin
    out_valid = (state_reg != ST_IDLE);
    busy      = (state_reg != ST_IDLE);
    done      = done_reg;
    out_data  = '0;
    case (state_reg)
      ST_HDR:  out_data = HDR_BYTE;
      ST_PAD:  out_data = snapshot_reg[{idx_reg, 3'b000} +: 8];
      ST_STAT: out_data = {(count_reg != 5'd0), rpt_ovr_reg, 1'b0, count_reg};
`ifdef PAD_SNAPSHOT_CRC_EN
      ST_CRC:  out_data = crc_value;
`endif
      default: out_data = '0;
    endcase
  end

  // Frame datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot_reg <= '0;
      count_reg    <= '0;
      idx_reg      <= '0;
      overrun_reg  <= 1'b0;
      rpt_ovr_reg  <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= xfer && (state_next == ST_IDLE);

      if (capture) begin
        snapshot_reg <= snap_next;
        count_reg    <= count_next;
        idx_reg      <= 4'hF;
        // Requests dropped during the previous frame get reported in this one.
        rpt_ovr_reg  <= overrun_reg;
      end else if (xfer && state_reg == ST_PAD) begin
        idx_reg <= idx_reg - 4'd1;
      end else if (xfer && state_reg == ST_STAT) begin
        rpt_ovr_reg <= 1'b0;
      end

      // Any request while a frame is running (including on its last edge)
      // is dropped and flagged.
      if (snap_start && state_reg != ST_IDLE) begin
        overrun_reg <= 1'b1;
      end else if (capture) begin
        overrun_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tt_pad_snapshot.sv
// tb_tt_pad_snapshot -- directed bench for tt_pad_snapshot.
// Covers reset state, plain frame, contention status, random sink stalls,
// overrun reporting, mid-frame reset and (with PAD_SNAPSHOT_CRC_EN) CRC-8.
module tb_tt_pad_snapshot;

`ifdef PAD_SNAPSHOT_CRC_EN
  localparam int         FL      = 19;
  localparam logic [7:0] EXP_HDR = 8'hA6;
`else
  localparam int         FL      = 18;
  localparam logic [7:0] EXP_HDR = 8'hA5;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pad_y, pad_a, pad_oe, pad_ie, pad_sl, pad_cs, pad_pd, pad_pu;
  logic        snap_start;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] frame_q [0:18];
  logic [7:0] exp_q   [0:18];

  always #5 clk = ~clk;

  tt_pad_snapshot dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tt_bi_Y    (pad_y),
    .tt_bi_A    (pad_a),
    .tt_bi_OE   (pad_oe),
    .tt_bi_IE   (pad_ie),
    .tt_bi_SL   (pad_sl),
    .tt_bi_CS   (pad_cs),
    .tt_bi_PD   (pad_pd),
    .tt_bi_PU   (pad_pu),
    .snap_start (snap_start),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

`ifdef PAD_SNAPSHOT_CRC_EN
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int b = 0; b < 8; b++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction
`endif

  // Append the CRC byte (CRC build only) to the expected frame.
  task automatic close_exp();
`ifdef PAD_SNAPSHOT_CRC_EN
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < 18; k++) c = crc8_step(c, exp_q[k]);
    exp_q[18] = c;
`endif
  endtask

  task automatic fill_exp(input logic [7:0] pad_byte, input logic [7:0] stat);
    exp_q[0] = EXP_HDR;
    for (int k = 1; k <= 16; k++) exp_q[k] = pad_byte;
    exp_q[17] = stat;
    exp_q[18] = 8'h00;
  endtask

  task automatic set_pads(input logic [15:0] y, a, oe, ie, sl, cs, pd, pu);
    pad_y = y; pad_a = a; pad_oe = oe; pad_ie = ie;
    pad_sl = sl; pad_cs = cs; pad_pd = pd; pad_pu = pu;
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_frame(input string tag);
    for (int k = 0; k < FL; k++) begin
      checks++;
      assert (frame_q[k] === exp_q[k])
        else begin failures++; $error("FAIL %s byte%0d got %h expected %h", tag, k, frame_q[k], exp_q[k]); end
    end
  endtask

  // Request a capture and drain the whole frame into frame_q.
  task automatic run_frame(input bit stalls, input bit mid_snap, input string tag);
    int         nb, cyc, last_cyc;
    bit         fired, hold;
    logic [7:0] held;
    nb = 0; cyc = 1; last_cyc = 0; fired = 0; hold = 0; held = '0;
    for (int k = 0; k < 19; k++) frame_q[k] = 8'hxx;
    out_ready = 1'b0;
    @(negedge clk); snap_start = 1'b1;
    @(negedge clk); snap_start = 1'b0;
    checks++;
    assert ({busy, out_valid, out_data} === {2'b11, EXP_HDR})
      else begin failures++; $error("FAIL %s start busy=%b valid=%b data=%h expected 1 1 %h", tag, busy, out_valid, out_data, EXP_HDR); end
    while (nb < FL && cyc < 400) begin
      snap_start = 1'b0;
      if (hold) begin
        checks++;
        assert ({out_valid, out_data} === {1'b1, held})
          else begin failures++; $error("FAIL %s stall_hold valid=%b data=%h expected 1 %h", tag, out_valid, out_data, held); end
      end
      hold = 1'b0;
      out_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        frame_q[nb] = out_data;
        nb++;
        last_cyc = cyc;
      end else if (out_valid) begin
        hold = 1'b1;
        held = out_data;
      end
      if (mid_snap && !fired && nb == 8) begin
        snap_start = 1'b1;
        fired = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    snap_start = 1'b0;
    checks++;
    assert (nb === FL)
      else begin failures++; $error("FAIL %s byte_count got %0d expected %0d", tag, nb, FL); end
    if (!stalls) begin
      checks++;
      assert (last_cyc === FL)
        else begin failures++; $error("FAIL %s last_handshake got E+%0d expected E+%0d", tag, last_cyc, FL); end
    end
    checks++;
    assert ({done, busy, out_valid} === 3'b100)
      else begin failures++; $error("FAIL %s done_edge done/busy/valid got %b expected 100", tag, {done, busy, out_valid}); end
    @(negedge clk);
    checks++;
    assert (done === 1'b0)
      else begin failures++; $error("FAIL %s done_pulse got %b expected 0", tag, done); end
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; snap_start = 1'b0; out_ready = 1'b0;
    pad_y = '0; pad_a = '0; pad_oe = '0; pad_ie = '0;
    pad_sl = '0; pad_cs = '0; pad_pd = '0; pad_pu = '0;
    repeat (3) @(negedge clk);
    checks++;
    assert ({out_valid, busy, done, out_data} === 11'd0)
      else begin failures++; $error("FAIL reset valid/busy/done/data got %b %b %b %h expected 0 0 0 00", out_valid, busy, done, out_data); end
    rst_n = 1'b1;

    // Y all high, controls low: every pad byte is 01, no contention.
    set_pads(16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    fill_exp(8'h01, 8'h00); close_exp();
    run_frame(1'b0, 1'b0, "t1_plain");
    compare_frame("t1_plain");

    // Contention on pad 3 only: pad 3 is the 13th byte of the frame.
    set_pads(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0008, 16'h0008);
    fill_exp(8'h00, 8'h81); exp_q[13] = 8'hC0; close_exp();
    run_frame(1'b0, 1'b0, "t2_pad3");
    compare_frame("t2_pad3");

    // Contention on all pads, with a stalling sink.
    set_pads(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF);
    fill_exp(8'hC0, 8'h90); close_exp();
    run_frame(1'b1, 1'b0, "t3_all_stall");
    compare_frame("t3_all_stall");

    // Mixed control bits per pad: pad p gets A=p[0], OE=p[1], CS=p[2], PU=p[3].
    set_pads(16'h0, 16'hAAAA, 16'hCCCC, 16'h0, 16'h0, 16'hF0F0, 16'h0, 16'hFF00);
    for (int p = 0; p < 16; p++) exp_q[16-p] = {p[3], 1'b0, p[2], 2'b00, p[1], p[0], 1'b0};
    exp_q[0] = EXP_HDR; exp_q[17] = 8'h00; close_exp();
    run_frame(1'b1, 1'b0, "t4_mixed");
    compare_frame("t4_mixed");

    // Overrun: request mid-PAD; reported in the next frame only.
    set_pads(16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    fill_exp(8'h01, 8'h00); close_exp();
    run_frame(1'b1, 1'b1, "ovr_f1");
    compare_frame("ovr_f1");
    fill_exp(8'h01, 8'h40); close_exp();
    run_frame(1'b0, 1'b0, "ovr_f2");
    compare_frame("ovr_f2");
    fill_exp(8'h01, 8'h00); close_exp();
    run_frame(1'b0, 1'b0, "ovr_f3");
    compare_frame("ovr_f3");

    // Reset while the 8th pad byte is on the bus.
    out_ready = 1'b1;
    @(negedge clk); snap_start = 1'b1;
    @(negedge clk); snap_start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    assert ({out_valid, out_data} === {1'b1, 8'h01})
      else begin failures++; $error("FAIL rst_mid pre valid=%b data=%h expected 1 01", out_valid, out_data); end
    rst_n = 1'b0;
    #1;
    checks++;
    assert ({out_valid, busy} === 2'b00)
      else begin failures++; $error("FAIL rst_mid async valid/busy got %b expected 00", {out_valid, busy}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    fill_exp(8'h01, 8'h00); close_exp();
    run_frame(1'b0, 1'b0, "rst_after");
    compare_frame("rst_after");

`ifdef PAD_SNAPSHOT_CRC_EN
    // Random snapshots, CRC byte from the bench model.
    for (int n = 0; n < 3; n++) begin
      logic [4:0] cnt;
      set_pads(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      exp_q[0] = EXP_HDR;
      for (int p = 0; p < 16; p++)
        exp_q[16-p] = {pad_pu[p], pad_pd[p], pad_cs[p], pad_sl[p], pad_ie[p], pad_oe[p], pad_a[p], pad_y[p]};
      cnt = 5'($countones(pad_pu & pad_pd));
      exp_q[17] = {(cnt != 5'd0), 2'b00, cnt};
      close_exp();
      run_frame(1'b1, 1'b0, "crc_rand");
      compare_frame("crc_rand");
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
